time_display: RTL

Display back-end for the stopwatch/timer datapath. It consumes the `time_min`/`time_sec`/`time_ms` outputs of the time counter and converts a frame-aligned snapshot to BCD with a small sequential subtractor. It then drives a 4-digit, time-multiplexed, common-anode 7-segment display. It sits between the time counter and the board display pins, in the same clock domain as the counter's fast clock.

---
 rtl/time_display.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/time_display.sv
// time_display: snapshots the time counter once per display frame, converts the
// snapshot to four BCD digits with a one-subtraction-per-cycle datapath, and
// scans the digits onto a 4-digit common-anode 7-segment display.
module time_display #(
  parameter int unsigned DIGIT_CYCLES = 100000
) (
  input  logic        clk_high_speed,
  input  logic        rst,
  input  logic [5:0]  time_min,
  input  logic [5:0]  time_sec,
  input  logic [9:0]  time_ms,
  input  logic        mode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [15:0] bcd,
  output logic        bcd_valid
);

  localparam int unsigned TickW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(DIGIT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StConv,
    StUpdate
  } state_e;

  // Scan counter state
  logic [TickW-1:0] tick_q;
  logic [1:0]       digit_idx_q;
  logic             tick_wrap;
  logic             frame_end;

  // Conversion state
  state_e      state_q;
  logic        first_q;
  logic        snap_mode_q;
  logic [5:0]  hi_q;
  logic [9:0]  lo_q;
  logic [3:0]  d3_q;
  logic [3:0]  d2_q;
  logic [3:0]  d1_q;
  logic [3:0]  d0_q;
  logic [15:0] bcd_q;
  logic        bcd_valid_q;

  // Display drive state
  logic [6:0]  seg_q;
  logic        dp_q;
  logic [3:0]  an_q;
  logic [3:0]  cur_nibble;

  assign tick_wrap = (tick_q == TickLast);
  assign frame_end = tick_wrap && (digit_idx_q == 2'd3);

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles blank the digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  // Digit slot timing: tick_cnt runs a full slot, then the scan moves to the next digit.
  always_ff @(posedge clk_high_speed) begin
    if (rst) begin
      tick_q      <= '0;
      digit_idx_q <= 2'd0;
    end else if (tick_wrap) begin
      tick_q      <= '0;
      digit_idx_q <= digit_idx_q + 2'd1;
    end else begin
      tick_q      <= tick_q + TickW'(1);
    end
  end

  // Capture/convert/update sequencer; one subtraction per CONV cycle.
  always_ff @(posedge clk_high_speed) begin
    if (rst) begin
      state_q     <= StIdle;
      first_q     <= 1'b1;
      snap_mode_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      d3_q        <= '0;
      d2_q        <= '0;
      d1_q        <= '0;
      d0_q        <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      bcd_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (first_q || frame_end) begin
            first_q <= 1'b0;
            state_q <= StCapture;
          end
        end
        StCapture: begin
          snap_mode_q <= mode;
          d3_q        <= '0;
          d2_q        <= '0;
          d1_q        <= '0;
          d0_q        <= '0;
          if (mode) begin
            hi_q <= time_sec;
            // Out-of-range ms saturates to 999 so the hundredths read 99.
            lo_q <= (time_ms >= 10'd1000) ? 10'd999 : time_ms;
          end else begin
            hi_q <= time_min;
            lo_q <= {4'd0, time_sec};
          end
          state_q <= StConv;
        end
        StConv: begin
          if (hi_q >= 6'd10) begin
            hi_q <= hi_q - 6'd10;
            d3_q <= d3_q + 4'd1;
          end else if (snap_mode_q && (lo_q >= 10'd100)) begin
            lo_q <= lo_q - 10'd100;
            d1_q <= d1_q + 4'd1;
          end else if (lo_q >= 10'd10) begin
            lo_q <= lo_q - 10'd10;
            if (snap_mode_q) begin
              d0_q <= d0_q + 4'd1;
            end else begin
              d1_q <= d1_q + 4'd1;
            end
          end else begin
            // Remainders are the ones digits; in SS.hh the ms ones digit is dropped.
            d2_q <= hi_q[3:0];
            if (!snap_mode_q) begin
              d0_q <= lo_q[3:0];
            end
            state_q <= StUpdate;
          end
        end
        StUpdate: begin
          bcd_q       <= {d3_q, d2_q, d1_q, d0_q};
          bcd_valid_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Nibble of the currently scanned digit
  always_comb begin
    cur_nibble = 4'd0;
    unique case (digit_idx_q)
      2'd0: cur_nibble = bcd_q[3:0];
      2'd1: cur_nibble = bcd_q[7:4];
      2'd2: cur_nibble = bcd_q[11:8];
      2'd3: cur_nibble = bcd_q[15:12];
      default: cur_nibble = 4'd0;
    endcase
  end

  // Registered pin drive so anode, segments and point switch on the same edge.
  always_ff @(posedge clk_high_speed) begin
    if (rst) begin
      an_q  <= 4'hF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= ~(4'b0001 << digit_idx_q);
      seg_q <= seg_decode(cur_nibble);
      dp_q  <= (digit_idx_q != 2'd2);
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign an        = an_q;
  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;

endmodule
